// File: rtl/lane_word_aligner.sv
// lane_word_aligner: per-lane pair packing and training-word alignment through bitslip requests
module lane_word_aligner #(
    parameter int LANES = 4,
    parameter int WORD_BITS = 16,
    parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = 16'h00FF,
    parameter int SLIP_WAIT = 4,
    parameter int LOCK_COUNT = 4
) (
    input  logic                       dco_clk,
    input  logic                       rst_n,
    input  logic [LANES-1:0]           bit_rise,
    input  logic [LANES-1:0]           bit_fall,
    input  logic                       align_en,
    output logic [LANES-1:0]           bitslip_pulse,
    output logic [LANES*WORD_BITS-1:0] word_out,
    output logic [LANES-1:0]           word_valid,
    output logic [LANES-1:0]           lane_locked,
    output logic [LANES-1:0]           align_fail
);
    localparam int PAIRS = WORD_BITS / 2;
    localparam int CW = PAIRS > 1 ? $clog2(PAIRS) : 1;
    localparam int AW = $clog2(WORD_BITS + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    typedef enum logic [2:0] {IDLE, CHECK, SLIP, LOCKED, FAIL} state_t;
    logic [CW-1:0] cnt;
    always_ff @(posedge dco_clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (cnt == CW'(PAIRS - 1)) ? '0 : cnt + 1'b1;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t st;
        logic [WORD_BITS-1:0] sr, word, nxt;
        logic [CW-1:0] offset;
        logic slip_st, skip, cap, pulse, valid, locked, fail;
        logic [MW-1:0] match_cnt;
        logic [AW-1:0] attempts;
        logic [WW-1:0] wait_cnt;
        assign nxt = {sr[WORD_BITS-3:0], bit_rise[i], bit_fall[i]};
        assign cap = cnt == offset;
        assign word_out[i*WORD_BITS +: WORD_BITS] = word;
        assign bitslip_pulse[i] = pulse;
        assign word_valid[i] = valid;
        assign lane_locked[i] = locked;
        assign align_fail[i] = fail;
        always_ff @(posedge dco_clk or negedge rst_n) begin
            if (!rst_n) begin
                st <= IDLE;
                sr <= '0;
                word <= '0;
                offset <= '0;
                slip_st <= 1'b0;
                skip <= 1'b0;
                match_cnt <= '0;
                attempts <= '0;
                wait_cnt <= '0;
                pulse <= 1'b0;
                valid <= 1'b0;
                locked <= 1'b0;
                fail <= 1'b0;
            end else begin
                sr <= nxt;
                valid <= cap;
                if (cap) word <= nxt;
                pulse <= 1'b0;
                if (!align_en) begin
                    st <= IDLE;
                    match_cnt <= '0;
                    attempts <= '0;
                    locked <= 1'b0;
                    fail <= 1'b0;
                end else begin
                    case (st)
                        IDLE: begin
                            st <= CHECK;
                            skip <= 1'b1;
                        end
                        CHECK: if (cap) begin
                            if (skip) skip <= 1'b0;
                            else if (nxt == TRAIN_PATTERN) begin
                                match_cnt <= match_cnt + 1'b1;
                                if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                                    st <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                                attempts <= attempts + 1'b1;
                                if (attempts == AW'(WORD_BITS - 1)) begin
                                    st <= FAIL;
                                    fail <= 1'b1;
                                end else begin
                                    // slip_st 0->1 delays one bit; 1->0 plus offset+1 nets a two-bit step
                                    pulse <= 1'b1;
                                    if (slip_st) offset <= (offset == CW'(PAIRS - 1)) ? '0 : offset + 1'b1;
                                    slip_st <= !slip_st;
                                    wait_cnt <= '0;
                                    st <= SLIP;
                                end
                            end
                        end
                        SLIP: if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
                            st <= CHECK;
                            skip <= 1'b1;
                        end else wait_cnt <= wait_cnt + 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_lane_word_aligner.sv
// tb_lane_word_aligner: directed scenarios for lane_word_aligner driven through a behavioural lane_bitslip model
`timescale 1ns/1ps
module tb_lane_word_aligner;
    localparam int LANES = 4;
    localparam int WB = 16;
    localparam int SW = 4;
    logic dco_clk = 1'b0;
    logic rst_n = 1'b0;
    logic align_en = 1'b0;
    logic [LANES-1:0] bit_rise = '0;
    logic [LANES-1:0] bit_fall = '0;
    logic [LANES-1:0] bitslip_pulse, word_valid, lane_locked, align_fail;
    logic [LANES*WB-1:0] word_out;
    logic [15:0] pat = 16'h00FF;
    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;
    int lane_e [LANES];
    int pulses [LANES];
    int last_pulse [LANES];
    int min_gap [LANES];
    logic [LANES-1:0] zero_mode = '0;
    logic [LANES-1:0] bs = '0;
    logic [LANES-1:0] prev_fall = '0;
    logic [LANES-1:0] ever_locked = '0;

    always #5 dco_clk = ~dco_clk;

    lane_word_aligner #(
        .LANES(LANES), .WORD_BITS(WB), .TRAIN_PATTERN(16'h00FF), .SLIP_WAIT(SW), .LOCK_COUNT(4)
    ) dut (
        .dco_clk(dco_clk), .rst_n(rst_n), .bit_rise(bit_rise), .bit_fall(bit_fall),
        .align_en(align_en), .bitslip_pulse(bitslip_pulse), .word_out(word_out),
        .word_valid(word_valid), .lane_locked(lane_locked), .align_fail(align_fail)
    );

    // serial bit k of a lane's stream; delay e=0 lines up with offset 0 and no slip
    function automatic logic sbit(int lane, int k);
        int idx;
        if (zero_mode[lane]) return 1'b0;
        idx = ((k + 14 + lane_e[lane]) % 16 + 16) % 16;
        return pat[15 - idx];
    endfunction

    task automatic step();
        logic [LANES-1:0] r, f, p;
        for (int i = 0; i < LANES; i++) begin
            r[i] = sbit(i, 2 * n);
            f[i] = sbit(i, 2 * n + 1);
            bit_rise[i] = bs[i] ? prev_fall[i] : r[i];
            bit_fall[i] = bs[i] ? r[i] : f[i];
        end
        p = bitslip_pulse;
        @(posedge dco_clk);
        #1;
        for (int i = 0; i < LANES; i++) begin
            prev_fall[i] = f[i];
            if (p[i]) begin
                bs[i] = ~bs[i];
                pulses[i]++;
                if (n - last_pulse[i] < min_gap[i]) min_gap[i] = n - last_pulse[i];
                last_pulse[i] = n;
            end
            if (lane_locked[i]) ever_locked[i] = 1'b1;
        end
        n++;
    endtask

    task automatic do_reset(input logic en);
        @(posedge dco_clk);
        #1;
        rst_n = 1'b0;
        align_en = 1'b0;
        repeat (2) begin
            bit_rise = LANES'($urandom);
            bit_fall = LANES'($urandom);
            @(posedge dco_clk);
        end
        #1;
        bs = '0;
        prev_fall = '0;
        ever_locked = '0;
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            pulses[i] = 0;
            last_pulse[i] = -1000;
            min_gap[i] = 1 << 30;
        end
        align_en = en;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        lane_e = '{default: 0};
        zero_mode = '0;
        rst_n = 1'b0;
        align_en = 1'b0;
        repeat (2) begin
            bit_rise = LANES'($urandom);
            bit_fall = LANES'($urandom);
            @(posedge dco_clk);
        end
        #1;
        n_cmp++;
        if ({bitslip_pulse, word_valid, lane_locked, align_fail} !== '0) begin
            n_bad++;
            $display("FAIL reset_flags: got %h want 0", {bitslip_pulse, word_valid, lane_locked, align_fail});
        end
        n_cmp++;
        if (word_out !== '0) begin
            n_bad++;
            $display("FAIL reset_word: got %h want 0", word_out);
        end
        do_reset(1'b0);
        n_cmp++;
        if (word_valid !== '0) begin
            n_bad++;
            $display("FAIL valid_before_capture: got %b want 0000", word_valid);
        end
        step();
        n_cmp++;
        if (word_valid !== 4'hF) begin
            n_bad++;
            $display("FAIL first_capture_valid: got %b want 1111", word_valid);
        end
        n_cmp++;
        if (word_out !== {4{16'h0003}}) begin
            n_bad++;
            $display("FAIL first_capture_word: got %h want %h", word_out, {4{16'h0003}});
        end
        step();
        n_cmp++;
        if (word_valid !== 4'h0) begin
            n_bad++;
            $display("FAIL valid_one_cycle: got %b want 0000", word_valid);
        end
        repeat (7) step();
        n_cmp++;
        if (word_out[15:0] !== 16'h00FF) begin
            n_bad++;
            $display("FAIL aligned_capture: got %h want 00ff", word_out[15:0]);
        end
        n_cmp++;
        if ({bitslip_pulse, lane_locked, align_fail} !== '0 || pulses[0] != 0) begin
            n_bad++;
            $display("FAIL idle_quiet: got %h/%0d want 0/0", {bitslip_pulse, lane_locked, align_fail}, pulses[0]);
        end
    endtask

    task automatic test_prealigned();
        lane_e = '{default: 0};
        zero_mode = '0;
        do_reset(1'b1);
        repeat (40) step();
        n_cmp++;
        if (lane_locked[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL prealigned_early_lock: got %b want 0", lane_locked[0]);
        end
        step();
        n_cmp++;
        if (lane_locked[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL prealigned_lock: got %b want 1", lane_locked[0]);
        end
        n_cmp++;
        if (word_out[15:0] !== 16'h00FF || word_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL prealigned_word: got %h/%b want 00ff/1", word_out[15:0], word_valid[0]);
        end
        repeat (20) step();
        n_cmp++;
        if (pulses[0] + pulses[1] + pulses[2] + pulses[3] != 0 || lane_locked !== 4'hF) begin
            n_bad++;
            $display("FAIL prealigned_pulses: got %0d/%b want 0/1111", pulses[0] + pulses[1] + pulses[2] + pulses[3], lane_locked);
        end
    endtask

    task automatic test_misaligned();
        lane_e = '{default: 0};
        lane_e[0] = -1;
        zero_mode = '0;
        do_reset(1'b1);
        for (int c = 0; c < 300 && !lane_locked[0]; c++) step();
        n_cmp++;
        if (lane_locked[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL misaligned_lock: got %b want 1", lane_locked[0]);
        end
        n_cmp++;
        if (pulses[0] != 3) begin
            n_bad++;
            $display("FAIL misaligned_pulses: got %0d want 3", pulses[0]);
        end
        n_cmp++;
        if (min_gap[0] < SW + 1) begin
            n_bad++;
            $display("FAIL misaligned_gap: got %0d want >= %0d", min_gap[0], SW + 1);
        end
        n_cmp++;
        if (bs[0] !== 1'b1 || word_out[15:0] !== 16'h00FF) begin
            n_bad++;
            $display("FAIL misaligned_state: got slip %b word %h want 1/00ff", bs[0], word_out[15:0]);
        end
        while (n % 8 != 2) step();
        n_cmp++;
        if (word_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL misaligned_offset1: got %b want 1", word_valid[0]);
        end
        step();
        n_cmp++;
        if (word_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL misaligned_offset_phase: got %b want 0", word_valid[0]);
        end
    endtask

    task automatic test_garbage();
        lane_e = '{default: 0};
        zero_mode = 4'b0001;
        do_reset(1'b1);
        for (int c = 0; c < 600 && !align_fail[0]; c++) step();
        n_cmp++;
        if (align_fail[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL garbage_fail: got %b want 1", align_fail[0]);
        end
        n_cmp++;
        if (pulses[0] != 15) begin
            n_bad++;
            $display("FAIL garbage_pulses: got %0d want 15", pulses[0]);
        end
        repeat (30) step();
        n_cmp++;
        if (pulses[0] != 15 || align_fail[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL garbage_after_fail: got %0d/%b want 15/1", pulses[0], align_fail[0]);
        end
        n_cmp++;
        if (ever_locked[0] !== 1'b0 || min_gap[0] < 2) begin
            n_bad++;
            $display("FAIL garbage_lock_or_double: got %b/%0d want 0/>=2", ever_locked[0], min_gap[0]);
        end
    endtask

    task automatic test_align_en_drop();
        lane_e = '{default: 0};
        lane_e[0] = -1;
        zero_mode = '0;
        do_reset(1'b1);
        for (int c = 0; c < 100 && pulses[0] == 0; c++) step();
        n_cmp++;
        if (pulses[0] != 1) begin
            n_bad++;
            $display("FAIL drop_first_pulse: got %0d want 1", pulses[0]);
        end
        align_en = 1'b0;
        step();
        n_cmp++;
        if ({lane_locked, align_fail, bitslip_pulse} !== '0) begin
            n_bad++;
            $display("FAIL drop_flags: got %h want 0", {lane_locked, align_fail, bitslip_pulse});
        end
        repeat (40) step();
        n_cmp++;
        if (pulses[0] != 1) begin
            n_bad++;
            $display("FAIL drop_no_pulse: got %0d want 1", pulses[0]);
        end
        align_en = 1'b1;
        for (int c = 0; c < 300 && !lane_locked[0]; c++) step();
        n_cmp++;
        if (lane_locked[0] !== 1'b1 || pulses[0] != 3) begin
            n_bad++;
            $display("FAIL drop_resume: got lock %b pulses %0d want 1/3", lane_locked[0], pulses[0]);
        end
        n_cmp++;
        if (bs[0] !== 1'b1 || word_out[15:0] !== 16'h00FF) begin
            n_bad++;
            $display("FAIL drop_resume_state: got %b/%h want 1/00ff", bs[0], word_out[15:0]);
        end
    endtask

    task automatic test_multi_lane();
        lane_e = '{default: 0};
        lane_e[2] = -2;
        zero_mode = '0;
        do_reset(1'b1);
        for (int c = 0; c < 300 && !(lane_locked[0] && lane_locked[2]); c++) step();
        n_cmp++;
        if (lane_locked !== 4'hF) begin
            n_bad++;
            $display("FAIL multi_lock: got %b want 1111", lane_locked);
        end
        n_cmp++;
        if (pulses[2] != 2 || pulses[0] + pulses[1] + pulses[3] != 0) begin
            n_bad++;
            $display("FAIL multi_pulses: got lane2 %0d others %0d want 2/0", pulses[2], pulses[0] + pulses[1] + pulses[3]);
        end
        while (n % 8 != 1) step();
        n_cmp++;
        if (word_valid[0] !== 1'b1 || word_valid[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL multi_phase0: got %b want x0x1", word_valid);
        end
        step();
        n_cmp++;
        if (word_valid[0] !== 1'b0 || word_valid[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL multi_phase1: got %b want x1x0", word_valid);
        end
        n_cmp++;
        if (word_out[47:32] !== 16'h00FF || word_out[15:0] !== 16'h00FF) begin
            n_bad++;
            $display("FAIL multi_words: got %h/%h want 00ff/00ff", word_out[47:32], word_out[15:0]);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bitslip_pulse, word_valid, lane_locked, align_fail} !== '0 || word_out !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %h/%h want 0/0", {bitslip_pulse, word_valid, lane_locked, align_fail}, word_out);
        end
        do_reset(1'b0);
    endtask

    initial begin
        test_reset();
        test_prealigned();
        test_misaligned();
        test_garbage();
        test_align_en_drop();
        test_multi_lane();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lane_word_aligner.md
# lane_word_aligner

Per-lane deserializer and training-pattern aligner that sits directly downstream of `lane_bitslip`. It packs the slip-corrected rise/fall bit pairs into `WORD_BITS`-bit words and hunts for a known training word by issuing `bitslip_pulse` requests and shifting its own word boundary. It declares per-lane lock or failure, then keeps emitting aligned words for the downstream sample path.

## Interface
- `LANES`, 4, number of data lanes, independent per-lane alignment.
- `WORD_BITS`, 16, word width; even, ≥4.
- `TRAIN_PATTERN`, 16'h00FF, `WORD_BITS`-wide training word; all rotations must be distinct.
- `SLIP_WAIT`, 4, idle cycles after each bitslip before words are checked again; ≥2.
- `LOCK_COUNT`, 4, consecutive matching words required for lock; ≥1.

- `dco_clk`  in  1  the one clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_rise`  in  LANES  earlier bit of each pair, from `lane_bitslip` `out_rise`.
- `bit_fall`  in  LANES  later bit of each pair, from `lane_bitslip` `out_fall`.
- `align_en`  in  1  level; high = run/hold alignment, low = return all lanes to IDLE.
- `bitslip_pulse`  out  LANES  one-cycle slip request to `lane_bitslip`; the bitslip stage toggles its slip state on each pulse.
- `word_out`  out  LANES*WORD_BITS  lane i in bits `[i*WORD_BITS +: WORD_BITS]`, MSB = oldest bit.
- `word_valid`  out  LANES  one-cycle strobe per lane when its `word_out` updates.
- `lane_locked`  out  LANES  level, lane in LOCKED.
- `align_fail`  out  LANES  level, lane in FAIL.

## Operation
- Shared pair counter `cnt` runs 0..WORD_BITS/2-1 and wraps; it increments every cycle, including during IDLE.
- Each lane has a shift register. Every posedge: `sr <= {sr[WORD_BITS-3:0], bit_rise[i], bit_fall[i]}`.
- Each lane captures a word when `cnt == offset[i]`: `word_out <= {sr[WORD_BITS-3:0], bit_rise, bit_fall}`, and `word_valid` is high for the following cycle. Capture continues in every state.
- Each lane holds `offset` (0..WORD_BITS/2-1) and `slip_st`, a mirror of the bitslip toggle state.
  - Both are cleared only by `rst_n`.
  - Both are retained across `align_en` toggles.
- Per-lane FSM:
  - IDLE: entered on reset or whenever `align_en`=0, from any state. Clears `match_cnt` and `attempts`. On `align_en`=1, go to CHECK with the first capture ignored.
  - CHECK, on each capture:
    - Word matches `TRAIN_PATTERN`: increment `match_cnt`. When `match_cnt` reaches `LOCK_COUNT`, go to LOCKED.
    - Word mismatches: clear `match_cnt` and increment `attempts`. If `attempts` reaches `WORD_BITS`, go to FAIL with no pulse.
    - Otherwise pulse `bitslip_pulse[i]`. If `slip_st`=1, advance `offset` by 1 mod WORD_BITS/2. Toggle `slip_st`. Go to SLIP_WAIT.
  - SLIP_WAIT: count `SLIP_WAIT` cycles, then go to CHECK. The first capture after re-entering CHECK is discarded because it spans old and new alignment.
  - LOCKED: `lane_locked`=1. Compare results are ignored and no pulses are issued.
  - FAIL: `align_fail`=1. No pulses are issued.
- Search order of bit delay d = 0, +1, −2, −1, −4, −3, … mod WORD_BITS. This covers all WORD_BITS positions within WORD_BITS attempts.

## Timing
- Reset values: all outputs 0; `cnt`, `offset`, `slip_st`, `sr`, `match_cnt`, `attempts` all 0; FSM in IDLE.
- Capture latency: a pair sampled at posedge N appears in `word_out` at posedge N (registered), with `word_valid` high in cycle N+1.
- `bitslip_pulse` is registered and asserted for exactly one cycle, in the cycle after the mismatching capture. It is never asserted outside that cycle and never on two consecutive cycles.
- `lane_locked` and `align_fail` assert in the cycle after the deciding capture.
- `align_en` falling: on the next posedge the lane is IDLE with `lane_locked`/`align_fail` = 0. A pending SLIP_WAIT is abandoned and no further pulse is issued.
- Asynchronous `rst_n` assertion mid-operation: all outputs clear immediately. The bench must also reset `lane_bitslip` so the `slip_st` mirror stays consistent.
- Lanes never interact except through the shared `cnt`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs. Required: every output is 0, and `word_valid` stays 0 until the first capture after release.
- Pre-aligned stream: 16'h00FF on lane 0, d=0, `align_en`=1. Required: zero `bitslip_pulse`, and `lane_locked[0]`=1 after 1 ignored word plus 4 matching words.
- Misaligned stream: bench instantiates real `lane_bitslip` and feeds the stream at d=−1. Required: exactly 3 pulses, each ≥ `SLIP_WAIT`+1 word spacing apart; final `offset`=1 and `slip_st`=1; then lock with `word_out`=16'h00FF.
- Garbage: constant 0 stream. Required: exactly 15 pulses, then `align_fail`=1, with `lane_locked`=0 throughout.
- `align_en` dropped during SLIP_WAIT. Required: no further pulse and flags 0. On re-enable, the lane resumes from the retained `offset`/`slip_st` and locks with the remaining pulse count only.
- Multi-lane: lane 0 at d=0 and lane 2 at d=−2. Required: pulses only on lane 2, exactly 2 of them; both lanes locked, each with an independent `word_valid` phase.
